// File: rtl/draw_cmd_sequencer_if.sv
// Bundle between the draw command sequencer, its command RAM and the draw unit.
// Handshakes: START is a 1-cycle request honoured only when BUSY=0; MEM_DATA is valid exactly one cycle after MEM_RD; ENB stays high until FINISH is accepted or the command times out, and DONE pulses once per list.
interface draw_cmd_sequencer_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [7:0]        cmd_count;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_data;
  logic [7:0]        cmd_type;
  logic [7:0]        x_0;
  logic [7:0]        y_0;
  logic [7:0]        x_1;
  logic [7:0]        y_1;
  logic [7:0]        x_2;
  logic [7:0]        y_2;
  logic              enb;
  logic              finish;
  logic              busy;
  logic              done;
  logic              error;
  logic [7:0]        cmd_idx;

  modport master (
    input  start, base_addr, cmd_count, mem_data, finish,
    output mem_addr, mem_rd, cmd_type, x_0, y_0, x_1, y_1, x_2, y_2,
           enb, busy, done, error, cmd_idx
  );

  modport slave (
    output start, base_addr, cmd_count, mem_data, finish,
    input  mem_addr, mem_rd, cmd_type, x_0, y_0, x_1, y_1, x_2, y_2,
           enb, busy, done, error, cmd_idx
  );
endinterface

// File: rtl/draw_cmd_sequencer.sv
// Fetches 7-byte draw commands from RAM and hands them one at a time to the draw unit,
// masking stale FINISH, timing out hung commands and reporting list completion.
module draw_cmd_sequencer #(
  parameter int ADDR_W     = 10,
  parameter int ARM_CYCLES = 3,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 65535
) (
  input  logic                    aclk_i,
  input  logic                    rst_i,
  draw_cmd_sequencer_if.master    bus,
  output logic [2:0]              dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CAPT, S_LOAD, S_GAP, S_ARM, S_RUN, S_NEXT
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [7:0]        count_q, count_d;
  logic [7:0]        idx_q, idx_d;
  logic              error_q, error_d;
  logic              done_q, done_d;
  logic              rd_q;
  logic [2:0]        rd_idx_q;
  logic [6:0][7:0]   shadow_q;
  logic [6:0][7:0]   cmd_q;
  logic              load_en;
  logic              mem_rd;

  always_ff @(posedge aclk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cmd_addr_q <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      error_q    <= 1'b0;
      done_q     <= 1'b0;
      rd_q       <= 1'b0;
      rd_idx_q   <= '0;
      shadow_q   <= '0;
      cmd_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_addr_q <= cmd_addr_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      error_q    <= error_d;
      done_q     <= done_d;
      rd_q       <= mem_rd;
      rd_idx_q   <= cnt_q[2:0];
      // RAM data lags the strobe by one cycle, so capture uses the delayed index
      if (rd_q) shadow_q[rd_idx_q] <= bus.mem_data;
      if (load_en) cmd_q <= shadow_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 16'd1;
    cmd_addr_d = cmd_addr_q;
    count_d    = count_q;
    idx_d      = idx_q;
    error_d    = error_q;
    done_d     = 1'b0;
    load_en    = 1'b0;
    mem_rd     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cmd_addr_d = bus.base_addr;
          count_d    = bus.cmd_count;
          error_d    = 1'b0;
          idx_d      = '0;
          if (bus.cmd_count == 8'd0) done_d = 1'b1;
          else                       state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        mem_rd = 1'b1;
        if (cnt_q == 16'd6) state_d = S_CAPT;
      end
      S_CAPT: state_d = S_LOAD;
      S_LOAD: begin
        load_en = 1'b1;
        state_d = S_GAP;
      end
      S_GAP: if (cnt_q == 16'(GAP_CYCLES - 1)) state_d = S_ARM;
      S_ARM: if (cnt_q == 16'(ARM_CYCLES - 1)) state_d = S_RUN;
      S_RUN: begin
        // FINISH takes priority over a timeout expiring in the same cycle
        if (bus.finish) begin
          state_d = S_NEXT;
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_NEXT: begin
        idx_d = idx_q + 8'd1;
        if (idx_q + 8'd1 == count_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cmd_addr_d = cmd_addr_q + ADDR_W'(7);
          state_d    = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  always_comb begin
    bus.mem_rd   = mem_rd;
    bus.mem_addr = mem_rd ? cmd_addr_q + ADDR_W'(cnt_q[2:0]) : '0;
    bus.cmd_type = cmd_q[0];
    bus.x_0      = cmd_q[1];
    bus.y_0      = cmd_q[2];
    bus.x_1      = cmd_q[3];
    bus.y_1      = cmd_q[4];
    bus.x_2      = cmd_q[5];
    bus.y_2      = cmd_q[6];
    bus.enb      = (state_q == S_ARM) || (state_q == S_RUN);
    bus.busy     = (state_q != S_IDLE);
    bus.done     = done_q;
    bus.error    = error_q;
    bus.cmd_idx  = idx_q;
    dbg_state_o  = state_q;
  end

endmodule
